// File: rtl/vend_cu_param_pkg.sv
// Shared definitions for the vending-machine control unit.
// Contents:
//   STATE_W   - width of the control-unit state register
//   state_t   - IDLE / CREDIT / VEND / CHANGE encodings
//   is_onehot - helper used for coin and product-select validation
package vend_cu_param_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  // True when exactly one bit of v is set (callers zero-extend narrower vectors).
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/vend_cu_param_if.sv
// Front-end / back-end bus of the vending-machine control unit.
// Signals:
//   coin_in     one-cycle coin pulse, one-hot per denomination
//   sel         one-cycle product select, one-hot
//   cancel      one-cycle refund request
//   price_bus   packed per-product prices, product i at [i*CW +: CW]
//   vend        one-hot dispense request, held until vend_ack
//   vend_ack    dispenser done
//   chg_req     change-hopper request, one unit per accepted beat
//   chg_ack     hopper accepts a beat when chg_req && chg_ack
//   credit      current credit
//   coin_reject one-cycle pulse: coin returned
//   deny        one-cycle pulse: select refused
//   busy        high while vending or paying change
// Modports: master = front-end/drivers side, slave = control unit.
interface vend_cu_param_if #(
  parameter int NPROD = 4,
  parameter int NCOIN = 3,
  parameter int CW    = 8
);

  logic [NCOIN-1:0]    coin_in;
  logic [NPROD-1:0]    sel;
  logic                cancel;
  logic [NPROD*CW-1:0] price_bus;
  logic [NPROD-1:0]    vend;
  logic                vend_ack;
  logic                chg_req;
  logic                chg_ack;
  logic [CW-1:0]       credit;
  logic                coin_reject;
  logic                deny;
  logic                busy;

  modport master (
    output coin_in, sel, cancel, price_bus, vend_ack, chg_ack,
    input  vend, chg_req, credit, coin_reject, deny, busy
  );

  modport slave (
    input  coin_in, sel, cancel, price_bus, vend_ack, chg_ack,
    output vend, chg_req, credit, coin_reject, deny, busy
  );

endinterface

// File: rtl/vend_cu_param_timer.sv
// Idle-timeout down-counter for the CREDIT state.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset
//   clr    in  reload the counter and drop any pending expiry
//   en     in  count one idle cycle
//   expire out one-cycle pulse after TIMEOUT consecutive enabled cycles
module vend_cu_param_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  // Count idle cycles; the TIMEOUT-th one raises expire for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= LOAD;
      expire <= 1'b0;
    end else if (clr) begin
      cnt    <= LOAD;
      expire <= 1'b0;
    end else if (en) begin
      if (cnt == {TW{1'b0}}) begin
        cnt    <= LOAD;
        expire <= 1'b1;
      end else begin
        cnt    <= cnt - {{(TW-1){1'b0}}, 1'b1};
        expire <= 1'b0;
      end
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/vend_cu_param.sv
// Parametrised vending-machine control unit: accumulates coin credit,
// checks a one-hot product select against its price, holds the vend
// request until the dispenser acknowledges, then pays change one
// CHG_UNIT per hopper beat. Cancel or an idle timeout in CREDIT refunds.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset (aborts any vend/change, credit lost)
//   bus  vend_cu_param_if.slave: coin/select/cancel/price inputs, vend and
//        change handshakes, registered credit and status outputs
module vend_cu_param
  import vend_cu_param_pkg::*;
#(
  parameter int                  NPROD     = 4,
  parameter int                  NCOIN     = 3,
  parameter int                  CW        = 8,
  parameter logic [NCOIN*CW-1:0] COIN_VALS = {8'd50, 8'd20, 8'd10},
  parameter int                  CHG_UNIT  = 10,
  parameter int                  TIMEOUT   = 1000
) (
  input logic           clk,
  input logic           rst,
  vend_cu_param_if.slave bus
);

  localparam logic [CW-1:0] UNIT = CW'(CHG_UNIT);

  state_t        state;
  logic [CW-1:0] cred;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] price_val;
  logic [CW:0]   coin_sum;
  logic [CW-1:0] change_left;
  logic          coin_any;
  logic          coin_ok;
  logic          sel_any;
  logic          sel_ok;
  logic          can_buy;
  logic          timer_clr;
  logic          timer_en;
  logic          expire;

  assign bus.credit = cred;

  // Input decode: coin value and selected price as OR-muxes, one-hot checks,
  // and a CW+1-bit sum so that an overflowing coin can be rejected.
  always_comb begin
    coin_val  = {CW{1'b0}};
    price_val = {CW{1'b0}};
    for (int i = 0; i < NCOIN; i++) begin
      coin_val = coin_val | (bus.coin_in[i] ? COIN_VALS[i*CW +: CW] : {CW{1'b0}});
    end
    for (int j = 0; j < NPROD; j++) begin
      price_val = price_val | (bus.sel[j] ? bus.price_bus[j*CW +: CW] : {CW{1'b0}});
    end
    coin_any    = |bus.coin_in;
    sel_any     = |bus.sel;
    coin_sum    = {1'b0, cred} + {1'b0, coin_val};
    coin_ok     = is_onehot(32'(bus.coin_in)) && !coin_sum[CW];
    sel_ok      = is_onehot(32'(bus.sel));
    can_buy     = (cred >= price_val);
    change_left = cred - UNIT;
    // Any coin or select activity, or leaving CREDIT, restarts the idle window.
    timer_en    = (state == ST_CREDIT);
    timer_clr   = (state != ST_CREDIT) || coin_any || sel_any || expire;
  end

  vend_cu_param_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (expire)
  );

  // Main control FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cred            <= {CW{1'b0}};
      bus.vend        <= {NPROD{1'b0}};
      bus.chg_req     <= 1'b0;
      bus.coin_reject <= 1'b0;
      bus.deny        <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.coin_reject <= 1'b0;
      bus.deny        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_any) begin
            if (coin_ok) begin
              cred  <= coin_sum[CW-1:0];
              state <= ST_CREDIT;
            end else begin
              bus.coin_reject <= 1'b1;
            end
          end
        end
        ST_CREDIT: begin
          // Priority: cancel/timeout, then select, then coin.
          if (bus.cancel || expire) begin
            state           <= ST_CHANGE;
            bus.busy        <= 1'b1;
            bus.chg_req     <= (cred >= UNIT);
            bus.coin_reject <= coin_any;
          end else if (sel_ok) begin
            bus.coin_reject <= coin_any;
            if (can_buy) begin
              cred     <= cred - price_val;
              bus.vend <= bus.sel;
              bus.busy <= 1'b1;
              state    <= ST_VEND;
            end else begin
              bus.deny <= 1'b1;
            end
          end else if (coin_any) begin
            if (coin_ok) begin
              cred <= coin_sum[CW-1:0];
            end else begin
              bus.coin_reject <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          bus.coin_reject <= coin_any;
          if (bus.vend_ack) begin
            bus.vend <= {NPROD{1'b0}};
            if (cred != {CW{1'b0}}) begin
              state       <= ST_CHANGE;
              bus.chg_req <= (cred >= UNIT);
            end else begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        ST_CHANGE: begin
          bus.coin_reject <= coin_any;
          if (bus.chg_req && bus.chg_ack) begin
            // Last beat: drop the request together with the credit reaching zero.
            if (change_left < UNIT) begin
              cred        <= {CW{1'b0}};
              bus.chg_req <= 1'b0;
              bus.busy    <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              cred <= change_left;
            end
          end else if (cred < UNIT) begin
            // Residual below one unit cannot be paid out; discard it.
            cred        <= {CW{1'b0}};
            bus.chg_req <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cred        <= {CW{1'b0}};
          bus.vend    <= {NPROD{1'b0}};
          bus.chg_req <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_cu_param.sv
// Self-checking bench for vend_cu_param: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_vend_cu_param;

  localparam int NPROD = 4;
  localparam int NCOIN = 3;
  localparam int CW    = 8;
  localparam int UNIT  = 10;
  localparam int TMO   = 40;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_cu_param_if #(.NPROD(NPROD), .NCOIN(NCOIN), .CW(CW)) bus ();

  vend_cu_param #(
    .NPROD(NPROD), .NCOIN(NCOIN), .CW(CW),
    .COIN_VALS({8'd50, 8'd20, 8'd10}),
    .CHG_UNIT(UNIT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: machine mode (0 idle, 1 credit, 2 vend, 3 change),
  // credit value, vended product index, and the idle-cycle run length.
  int coin_tab[NCOIN];
  int price[NPROD];
  int m_mode, m_credit, m_vend_idx, m_quiet;
  bit m_chg, m_rej, m_deny, m_forced;

  function automatic int idx_of(input int v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic load_prices();
    for (int i = 0; i < NPROD; i++) bus.price_bus[i*CW +: CW] = 8'(price[i]);
  endtask

  task automatic model_coin(input int coin);
    int v;
    if ($countones(coin) == 1) begin
      v = coin_tab[idx_of(coin)];
      if (m_credit + v <= MAXC) begin
        m_credit += v;
        m_mode = 1;
      end else m_rej = 1'b1;
    end else m_rej = 1'b1;
  endtask

  task automatic model_step(input int coin, input int sel, input bit cancel,
                            input bit vack, input bit cack, input bit r);
    int nc, ns, old_mode, p;
    bit old_forced;
    if (r) begin
      m_mode = 0; m_credit = 0; m_vend_idx = -1; m_quiet = 0;
      m_chg = 0; m_rej = 0; m_deny = 0; m_forced = 0;
      return;
    end
    nc = $countones(coin);
    ns = $countones(sel);
    old_mode = m_mode;
    old_forced = m_forced;
    m_rej = 0;
    m_deny = 0;
    case (old_mode)
      0: if (nc != 0) model_coin(coin);
      1: begin
        if (cancel || old_forced) begin
          m_mode = 3;
          m_chg = (m_credit >= UNIT);
          m_rej = (nc != 0);
        end else if (ns == 1) begin
          m_rej = (nc != 0);
          p = price[idx_of(sel)];
          if (m_credit >= p) begin
            m_credit -= p;
            m_vend_idx = idx_of(sel);
            m_mode = 2;
          end else m_deny = 1;
        end else if (nc != 0) model_coin(coin);
      end
      2: begin
        m_rej = (nc != 0);
        if (vack) begin
          m_vend_idx = -1;
          if (m_credit != 0) begin
            m_mode = 3;
            m_chg = (m_credit >= UNIT);
          end else m_mode = 0;
        end
      end
      3: begin
        m_rej = (nc != 0);
        if (m_chg && cack) begin
          m_credit -= UNIT;
          if (m_credit < UNIT) begin
            m_credit = 0; m_chg = 0; m_mode = 0;
          end
        end else if (m_credit < UNIT) begin
          m_credit = 0; m_chg = 0; m_mode = 0;
        end
      end
      default: m_mode = 0;
    endcase
    // Timeout bookkeeping: consecutive credit-state cycles with no coin/select.
    if (old_mode != 1 || nc != 0 || ns != 0 || old_forced) begin
      m_quiet = 0;
      m_forced = 0;
    end else begin
      m_quiet++;
      if (m_quiet == TMO) begin
        m_forced = 1;
        m_quiet = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_vend;
    exp_vend = (m_vend_idx >= 0) ? (32'd1 << m_vend_idx) : 32'd0;
    check("credit", 32'(bus.credit), 32'(m_credit));
    check("vend", 32'(bus.vend), exp_vend);
    check("chg_req", 32'(bus.chg_req), 32'(m_chg));
    check("coin_reject", 32'(bus.coin_reject), 32'(m_rej));
    check("deny", 32'(bus.deny), 32'(m_deny));
    check("busy", 32'(bus.busy), 32'((m_mode == 2) || (m_mode == 3)));
  endtask

  // One clock: drive at negedge, advance the model, sample #1 after posedge.
  task automatic cycle(input logic [NCOIN-1:0] coin, input logic [NPROD-1:0] sel,
                       input bit cancel, input bit vack, input bit cack, input bit r);
    @(negedge clk);
    bus.coin_in  = coin;
    bus.sel      = sel;
    bus.cancel   = cancel;
    bus.vend_ack = vack;
    bus.chg_ack  = cack;
    rst          = r;
    model_step(int'(coin), int'(sel), cancel, vack, cack, r);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_mode != 0; k++) cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("drain_idle_busy", 32'(bus.busy), 32'd0);
    check("drain_idle_credit", 32'(bus.credit), 32'd0);
  endtask

  initial begin
    logic [NCOIN-1:0] coin;
    logic [NPROD-1:0] sel;
    bit cancel, vack, cack, r, quiet;

    coin_tab[0] = 10; coin_tab[1] = 20; coin_tab[2] = 50;
    price[0] = 60; price[1] = 60; price[2] = 10; price[3] = 0;
    load_prices();
    bus.coin_in = 3'b000; bus.sel = 4'b0000; bus.cancel = 1'b0;
    bus.vend_ack = 1'b0; bus.chg_ack = 1'b0; rst = 1'b1;

    // Reset state.
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_credit", 32'(bus.credit), 32'd0);

    // 50 + 20, buy product 1 at 60, one change beat.
    cycle(3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(3'b010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("A_credit70", 32'(bus.credit), 32'd70);
    cycle(3'b000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    check("A_vend", 32'(bus.vend), 32'h2);
    for (int k = 0; k < 3; k++) cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("A_vend_held", 32'(bus.vend), 32'h2);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("A_chg_req", 32'(bus.chg_req), 32'd1);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("A_one_beat", 32'(bus.chg_req), 32'd0);
    check("A_credit0", 32'(bus.credit), 32'd0);

    // Insufficient credit -> deny, then cancel refunds two beats.
    cycle(3'b010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(3'b000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    check("B_deny", 32'(bus.deny), 32'd1);
    check("B_credit20", 32'(bus.credit), 32'd20);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("B_beat1", 32'(bus.credit), 32'd10);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("B_beat2", 32'(bus.credit), 32'd0);

    // Overflow: 250 + 10 rejected.
    for (int k = 0; k < 5; k++) cycle(3'b100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("C_reject", 32'(bus.coin_reject), 32'd1);
    check("C_credit250", 32'(bus.credit), 32'd250);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Select beats same-cycle coin.
    cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(3'b010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(3'b100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("D_vend", 32'(bus.vend), 32'h4);
    check("D_reject", 32'(bus.coin_reject), 32'd1);
    check("D_credit20", 32'(bus.credit), 32'd20);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Idle timeout, then a stalled hopper.
    cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < TMO; k++) cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("E_not_yet", 32'(bus.chg_req), 32'd0);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("E_timeout_chg", 32'(bus.chg_req), 32'd1);
    for (int k = 0; k < 5; k++) cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("E_stall_req", 32'(bus.chg_req), 32'd1);
    check("E_stall_credit", 32'(bus.credit), 32'd10);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("E_done", 32'(bus.busy), 32'd0);

    // Price 0 vend keeps credit.
    cycle(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(3'b000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("P0_vend", 32'(bus.vend), 32'h8);
    check("P0_credit", 32'(bus.credit), 32'd10);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset held two cycles in the middle of change.
    cycle(3'b010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("F_rst_chg", 32'(bus.chg_req), 32'd0);
    check("F_rst_credit", 32'(bus.credit), 32'd0);
    cycle(3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("F_idle_busy", 32'(bus.busy), 32'd0);

    // Randomized traffic with quiet stretches for timeouts.
    for (int i = 0; i < 4000; i++) begin
      if (m_mode == 0 && $urandom_range(0, 99) < 5) begin
        for (int j = 0; j < NPROD; j++) price[j] = 10 * int'($urandom_range(0, 12));
        load_prices();
      end
      quiet = (((i / 250) % 3) == 2);
      coin = 3'b000; sel = 4'b0000;
      if (!quiet && $urandom_range(0, 99) < 25) begin
        if ($urandom_range(0, 9) == 0) coin = 3'($urandom_range(1, 7));
        else coin = 3'(32'd1 << $urandom_range(0, 2));
      end
      if (!quiet && $urandom_range(0, 99) < 12) begin
        if ($urandom_range(0, 9) == 0) sel = 4'($urandom_range(1, 15));
        else sel = 4'(32'd1 << $urandom_range(0, 3));
      end
      cancel = !quiet && ($urandom_range(0, 99) < 3);
      vack = ($urandom_range(0, 99) < 35);
      cack = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 999) == 0);
      cycle(coin, sel, cancel, vack, cack, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
